norm_channel_accumulator: RTL and testbench

Consumer stage for the channel index produced by the normalization channel counter. Accepts one pre-reduced partial sum and one partial sum-of-squares per compute window, and accumulates them over the NUM_SPATIAL_BLOCKS windows of a channel. When a channel is complete, it emits one per-channel statistics beat {channel, sum, sumsq} to the mean/variance stage. It also generates the inc pulse that advances the channel counter, and flags any disagreement between the supplied channel index and its own internal tracking.

---
 rtl/norm_channel_accumulator.sv | 114 +++++++++++
 tb/tb_norm_channel_accumulator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/norm_channel_accumulator.sv
// Per-channel statistics accumulator: sums NUM_SPATIAL_BLOCKS window partials
// into one {channel, sum, sumsq} beat and tracks the expected channel index.
module norm_channel_accumulator #(
  parameter int unsigned NUM_CHANNELS       = 2,
  parameter int unsigned NUM_SPATIAL_BLOCKS = 4,
  parameter int unsigned IN_WIDTH           = 16,
  parameter int unsigned SQ_WIDTH           = 32,
  localparam int unsigned C_W          = (NUM_CHANNELS == 1) ? 1 : $clog2(NUM_CHANNELS),
  localparam int unsigned S_W          = (NUM_SPATIAL_BLOCKS == 1) ? 1 : $clog2(NUM_SPATIAL_BLOCKS),
  localparam int unsigned SUM_WIDTH    = IN_WIDTH + S_W,
  localparam int unsigned SQ_ACC_WIDTH = SQ_WIDTH + S_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_WIDTH-1:0]     in_sum,
  input  logic [SQ_WIDTH-1:0]     in_sumsq,
  input  logic [C_W-1:0]          in_channel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    inc,
  output logic [SUM_WIDTH-1:0]    out_sum,
  output logic [SQ_ACC_WIDTH-1:0] out_sumsq,
  output logic [C_W-1:0]          out_channel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_channel
);

  localparam bit SINGLE_BLOCK = (NUM_SPATIAL_BLOCKS == 1);

  logic [S_W-1:0]          spatial_cnt;
  logic [C_W-1:0]          exp_channel;
  logic [SUM_WIDTH-1:0]    acc_sum;
  logic [SQ_ACC_WIDTH-1:0] acc_sq;

  logic                    last_beat;
  logic                    accept;
  logic [SUM_WIDTH-1:0]    sum_ext;
  logic [SQ_ACC_WIDTH-1:0] sq_ext;
  logic [SUM_WIDTH-1:0]    sum_base;
  logic [SQ_ACC_WIDTH-1:0] sq_base;
  logic [SUM_WIDTH-1:0]    sum_total;
  logic [SQ_ACC_WIDTH-1:0] sq_total;

  // A last beat may only stall while the single output slot is still occupied.
  assign last_beat = (spatial_cnt == S_W'(NUM_SPATIAL_BLOCKS - 1));
  assign in_ready  = !last_beat || !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign inc       = accept;

  assign sum_ext   = {{S_W{in_sum[IN_WIDTH-1]}}, in_sum};
  assign sq_ext    = {{S_W{1'b0}}, in_sumsq};
  assign sum_base  = SINGLE_BLOCK ? '0 : acc_sum;
  assign sq_base   = SINGLE_BLOCK ? '0 : acc_sq;
  assign sum_total = sum_base + sum_ext;
  assign sq_total  = sq_base + sq_ext;

  // Window position and expected channel tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spatial_cnt <= '0;
      exp_channel <= '0;
    end else if (accept) begin
      if (last_beat) begin
        spatial_cnt <= '0;
        exp_channel <= (exp_channel == C_W'(NUM_CHANNELS - 1)) ? '0 : exp_channel + C_W'(1);
      end else begin
        spatial_cnt <= spatial_cnt + S_W'(1);
      end
    end
  end

  // First window of a channel loads the accumulators rather than adding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_sum <= '0;
      acc_sq  <= '0;
    end else if (accept && !last_beat) begin
      if (spatial_cnt == '0) begin
        acc_sum <= sum_ext;
        acc_sq  <= sq_ext;
      end else begin
        acc_sum <= sum_total;
        acc_sq  <= sq_total;
      end
    end
  end

  // Single-entry result register; a new result may replace one being consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_sum     <= '0;
      out_sumsq   <= '0;
      out_channel <= '0;
      out_valid   <= 1'b0;
    end else if (accept && last_beat) begin
      out_sum     <= sum_total;
      out_sumsq   <= sq_total;
      out_channel <= exp_channel;
      out_valid   <= 1'b1;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_channel <= 1'b0;
    end else if (accept && (in_channel != exp_channel)) begin
      err_channel <= 1'b1;
    end
  end

endmodule

// File: tb/tb_norm_channel_accumulator.sv
// Directed bench: main NC=2/NSB=4 instance plus an NSB=1 instance for throughput.
module tb_norm_channel_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (NC=2, NSB=4): SUM 18 bits, SQ 34 bits.
  logic [15:0] in_sum;
  logic [31:0] in_sumsq;
  logic [0:0]  in_channel;
  logic        in_valid, in_ready, inc;
  logic [17:0] out_sum;
  logic [33:0] out_sumsq;
  logic [0:0]  out_channel;
  logic        out_valid, out_ready, err_channel;

  // Single-block instance (NC=2, NSB=1): SUM 17 bits, SQ 33 bits.
  logic [15:0] o_in_sum;
  logic [31:0] o_in_sumsq;
  logic [0:0]  o_in_channel;
  logic        o_in_valid, o_in_ready, o_inc;
  logic [16:0] o_out_sum;
  logic [32:0] o_out_sumsq;
  logic [0:0]  o_out_channel;
  logic        o_out_valid, o_out_ready, o_err_channel;

  int checks = 0;
  int errors = 0;
  int inc_cnt = 0;

  norm_channel_accumulator #(.NUM_CHANNELS(2), .NUM_SPATIAL_BLOCKS(4),
                             .IN_WIDTH(16), .SQ_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .in_sum(in_sum), .in_sumsq(in_sumsq),
    .in_channel(in_channel), .in_valid(in_valid), .in_ready(in_ready), .inc(inc),
    .out_sum(out_sum), .out_sumsq(out_sumsq), .out_channel(out_channel),
    .out_valid(out_valid), .out_ready(out_ready), .err_channel(err_channel));

  norm_channel_accumulator #(.NUM_CHANNELS(2), .NUM_SPATIAL_BLOCKS(1),
                             .IN_WIDTH(16), .SQ_WIDTH(32)) u_one (
    .clk(clk), .rst(rst), .in_sum(o_in_sum), .in_sumsq(o_in_sumsq),
    .in_channel(o_in_channel), .in_valid(o_in_valid), .in_ready(o_in_ready), .inc(o_inc),
    .out_sum(o_out_sum), .out_sumsq(o_out_sumsq), .out_channel(o_out_channel),
    .out_valid(o_out_valid), .out_ready(o_out_ready), .err_channel(o_err_channel));

  always @(posedge clk) if (inc) inc_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted beat on the main instance; in_ready must be high.
  task automatic beat(input logic [15:0] s, input logic [31:0] q, input logic [0:0] ch);
    in_sum = s; in_sumsq = q; in_channel = ch; in_valid = 1'b1;
    #1;
    chk("beat_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic one_beat(input logic [15:0] s, input logic [0:0] ch,
                          input logic [16:0] exp_sum);
    o_in_sum = s; o_in_sumsq = 32'(s[7:0]); o_in_channel = ch; o_in_valid = 1'b1;
    #1;
    chk("nsb1_in_ready", 64'(o_in_ready), 64'd1);
    @(posedge clk); #1;
    chk("nsb1_out_valid", 64'(o_out_valid), 64'd1);
    chk("nsb1_out_sum", 64'(o_out_sum), 64'(exp_sum));
    chk("nsb1_out_channel", 64'(o_out_channel), 64'(ch));
  endtask

  initial begin
    rst = 1'b0;
    in_sum = '0; in_sumsq = '0; in_channel = '0; in_valid = 1'b0; out_ready = 1'b1;
    o_in_sum = '0; o_in_sumsq = '0; o_in_channel = '0; o_in_valid = 1'b0; o_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_err", 64'(err_channel), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic channel 0: 1..4 / 1,4,9,16
    beat(16'd1, 32'd1, 1'b0);
    beat(16'd2, 32'd4, 1'b0);
    beat(16'd3, 32'd9, 1'b0);
    chk("basic_no_early_valid", 64'(out_valid), 64'd0);
    beat(16'd4, 32'd16, 1'b0);
    chk("basic_valid", 64'(out_valid), 64'd1);
    chk("basic_sum", 64'(out_sum), 64'd10);
    chk("basic_sumsq", 64'(out_sumsq), 64'd30);
    chk("basic_channel", 64'(out_channel), 64'd0);
    chk("basic_inc_cnt", 64'(inc_cnt), 64'd4);
    @(posedge clk); #1;
    chk("basic_valid_clear", 64'(out_valid), 64'd0);

    // Signed channel 1: -5,3,-1,-2 -> -5
    beat(16'hFFFB, 32'd0, 1'b1);
    beat(16'd3,    32'd0, 1'b1);
    beat(16'hFFFF, 32'd0, 1'b1);
    beat(16'hFFFE, 32'd0, 1'b1);
    chk("signed_sum", 64'(out_sum), 64'h3FFFB);
    chk("signed_channel", 64'(out_channel), 64'd1);

    // Growth channel 0: 32767 x4 with max sumsq; held under backpressure
    beat(16'h7FFF, 32'hFFFF_FFFF, 1'b0);
    beat(16'h7FFF, 32'hFFFF_FFFF, 1'b0);
    beat(16'h7FFF, 32'hFFFF_FFFF, 1'b0);
    out_ready = 1'b0;
    beat(16'h7FFF, 32'hFFFF_FFFF, 1'b0);
    chk("big_sum", 64'(out_sum), 64'd131068);
    chk("big_sumsq", 64'(out_sumsq), 64'h3_FFFF_FFFC);
    chk("big_channel", 64'(out_channel), 64'd0);

    // Channel 1 while channel 0 result is pending
    beat(16'd10, 32'd1, 1'b1);
    beat(16'd20, 32'd1, 1'b1);
    beat(16'd30, 32'd1, 1'b1);
    in_sum = 16'd40; in_sumsq = 32'd1; in_channel = 1'b1; in_valid = 1'b1;
    #1;
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_sum", 64'(out_sum), 64'd131068);
    chk("bp_hold_channel", 64'(out_channel), 64'd0);
    chk("bp_inc_cnt", 64'(inc_cnt), 64'd15);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_new_valid", 64'(out_valid), 64'd1);
    chk("bp_new_sum", 64'(out_sum), 64'd100);
    chk("bp_new_sumsq", 64'(out_sumsq), 64'd4);
    chk("bp_new_channel", 64'(out_channel), 64'd1);
    chk("bp_inc_cnt2", 64'(inc_cnt), 64'd16);

    // Wrap: channels 0,1,0
    for (int i = 0; i < 4; i++) beat(16'd1, 32'd1, 1'b0);
    chk("wrap0_sum", 64'(out_sum), 64'd4);
    chk("wrap0_channel", 64'(out_channel), 64'd0);
    for (int i = 0; i < 4; i++) beat(16'd2, 32'd4, 1'b1);
    chk("wrap1_sum", 64'(out_sum), 64'd8);
    chk("wrap1_channel", 64'(out_channel), 64'd1);
    for (int i = 0; i < 4; i++) beat(16'd3, 32'd9, 1'b0);
    chk("wrap2_sum", 64'(out_sum), 64'd12);
    chk("wrap2_sumsq", 64'(out_sumsq), 64'd36);
    chk("wrap2_channel", 64'(out_channel), 64'd0);
    chk("wrap_no_err", 64'(err_channel), 64'd0);

    // Mismatch on first beat of channel 1
    beat(16'd5, 32'd25, 1'b0);
    chk("mis_err_set", 64'(err_channel), 64'd1);
    beat(16'd5, 32'd25, 1'b1);
    beat(16'd5, 32'd25, 1'b1);
    beat(16'd5, 32'd25, 1'b1);
    chk("mis_err_sticky", 64'(err_channel), 64'd1);
    chk("mis_sum", 64'(out_sum), 64'd20);
    chk("mis_sumsq", 64'(out_sumsq), 64'd100);
    chk("mis_channel", 64'(out_channel), 64'd1);

    // Reset mid-group with a pending result
    out_ready = 1'b0;
    beat(16'd9, 32'd9, 1'b0);
    beat(16'd9, 32'd9, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_err", 64'(err_channel), 64'd0);
    @(posedge clk); #1;
    chk("mid_rst_valid_hold", 64'(out_valid), 64'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) beat(16'd1, 32'd1, 1'b0);
    chk("post_rst_sum", 64'(out_sum), 64'd4);
    chk("post_rst_sumsq", 64'(out_sumsq), 64'd4);
    chk("post_rst_channel", 64'(out_channel), 64'd0);
    chk("post_rst_err", 64'(err_channel), 64'd0);

    // NSB=1: one result per beat, back-to-back
    one_beat(16'd7,    1'b0, 17'd7);
    one_beat(16'hFFFD, 1'b1, 17'h1FFFD);
    one_beat(16'd100,  1'b0, 17'd100);
    o_in_valid = 1'b0;
    chk("nsb1_sumsq", 64'(o_out_sumsq), 64'd100);
    chk("nsb1_err", 64'(o_err_channel), 64'd0);
    @(posedge clk); #1;
    chk("nsb1_drain", 64'(o_out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
